// File: rtl/pulse_gen_pkg.sv
// pulse_gen_ctrl shared types and defaults.
// Mode and state encodings used across the block.
package pulse_gen_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    MODE_SINGLE   = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_BURST    = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pulse_gen_ctrl_if.sv
// Control/status bundle between the register
// front-end and pulse_gen_ctrl.
interface pulse_gen_ctrl_if
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) ();

  logic               init;
  logic               stop;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   width;
  logic [BURST_W-1:0] burst_len;
  logic               pulse;
  logic               busy;
  logic               done;

  modport master (
    output init, stop, mode,
    output period, width, burst_len,
    input  pulse, busy, done
  );

  modport slave (
    input  init, stop, mode,
    input  period, width, burst_len,
    output pulse, busy, done
  );

endinterface

// File: rtl/pulse_gen_edge.sv
// Optional 2-flop sync (PULSE_GEN_CTRL_SYNC_EN)
// plus rising-edge detect on init; stop only synced.
module pulse_gen_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic init_in,
  input  logic stop_in,
  output logic trig,
  output logic stop_s
);

  logic init_s;
  logic init_dly_d;
  logic init_dly_q;

`ifdef PULSE_GEN_CTRL_SYNC_EN
  logic [1:0] init_sync_d;
  logic [1:0] init_sync_q;
  logic [1:0] stop_sync_d;
  logic [1:0] stop_sync_q;

  // shift the raw inputs into the sync chains
  always_comb begin
    init_sync_d = {init_sync_q[0], init_in};
    stop_sync_d = {stop_sync_q[0], stop_in};
  end

  // synchronizer flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_sync_q <= '0;
      stop_sync_q <= '0;
    end else begin
      init_sync_q <= init_sync_d;
      stop_sync_q <= stop_sync_d;
    end
  end

  assign init_s = init_sync_q[1];
  assign stop_s = stop_sync_q[1];
`else
  assign init_s = init_in;
  assign stop_s = stop_in;
`endif

  // previous init level for edge detect
  always_comb init_dly_d = init_s;

  // init delay flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_dly_q <= 1'b0;
    else        init_dly_q <= init_dly_d;
  end

  assign trig = init_s & ~init_dly_q;

endmodule

// File: rtl/pulse_gen_ctrl.sv
// Pulse generator: SINGLE/PERIODIC/BURST sequences.
// Build option: PULSE_GEN_CTRL_SYNC_EN syncs init/stop.
module pulse_gen_ctrl
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  pulse_gen_ctrl_if.slave bus
);

  logic trig;
  logic stop_s;

  pulse_gen_edge u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .init_in (bus.init),
    .stop_in (bus.stop),
    .trig    (trig),
    .stop_s  (stop_s)
  );

  state_e             state_d, state_q;
  mode_e              mode_d, mode_q;
  logic [CNT_W-1:0]   ph_d, ph_q;
  logic [CNT_W-1:0]   period_d, period_q;
  logic [CNT_W-1:0]   width_d, width_q;
  logic [BURST_W-1:0] rem_d, rem_q;
  logic               pulse_d, pulse_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;

  logic eop;
  logic last;
  logic do_stop;
  logic do_start;
  logic run;

  // next-state: stop > trig > period rollover
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ph_d     = ph_q;
    period_d = period_q;
    width_d  = width_q;
    rem_d    = rem_q;
    done_d   = 1'b0;

    eop  = (ph_q == period_q - CNT_W'(1));
    last = 1'b1;
    if (mode_q == MODE_PERIODIC) last = 1'b0;
    if (mode_q == MODE_BURST)
      last = (rem_q <= BURST_W'(1));

    do_stop  = stop_s;
    do_start = !stop_s && trig &&
               (bus.period != '0);
    run      = !do_stop && !do_start &&
               (state_q == ST_RUN);

    unique case (1'b1)
      do_stop: begin
        state_d = ST_IDLE;
        ph_d    = '0;
        rem_d   = '0;
      end
      do_start: begin
        state_d  = ST_RUN;
        mode_d   = mode_e'(bus.mode);
        period_d = bus.period;
        width_d  = bus.width;
        ph_d     = '0;
        rem_d    = (bus.burst_len == '0) ?
                   BURST_W'(1) : bus.burst_len;
      end
      (run && eop && !last): begin
        ph_d = '0;
        if (mode_q == MODE_BURST)
          rem_d = rem_q - BURST_W'(1);
      end
      (run && eop && last): begin
        state_d = ST_IDLE;
        ph_d    = '0;
        rem_d   = '0;
        done_d  = 1'b1;
      end
      (run && !eop): begin
        ph_d = ph_q + CNT_W'(1);
      end
      default: ;
    endcase

    busy_d  = (state_d == ST_RUN);
    pulse_d = busy_d && (ph_d < width_d);
  end

  // state, counters, latched params, outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_SINGLE;
      ph_q     <= '0;
      period_q <= '0;
      width_q  <= '0;
      rem_q    <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ph_q     <= ph_d;
      period_q <= period_d;
      width_q  <= width_d;
      rem_q    <= rem_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.pulse = pulse_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_pulse_gen_ctrl.sv
// Self-checking bench for pulse_gen_ctrl.
// Sequence-level model plus directed count checks.
module tb_pulse_gen_ctrl;

  localparam int CW = 16;
  localparam int BW = 8;
`ifdef PULSE_GEN_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pulse_gen_ctrl_if #(.CNT_W(CW), .BURST_W(BW)) bus ();

  pulse_gen_ctrl #(.CNT_W(CW), .BURST_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cnt_pulse = 0;
  int cnt_busy = 0;
  int cnt_done = 0;

  // sequence model: k = cycles since start
  bit m_active, m_done, m_prev;
  int m_k, m_per, m_wid, m_total;
  bit si1, si2, ss1, ss2;
  bit ei, es, tg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_prev = 0;
      m_k = 0; m_per = 1; m_wid = 0; m_total = 0;
      si1 = 0; si2 = 0; ss1 = 0; ss2 = 0;
    end else begin
`ifdef PULSE_GEN_CTRL_SYNC_EN
      ei = si2; es = ss2;
      si2 = si1; ss2 = ss1;
      si1 = bus.init; ss1 = bus.stop;
`else
      ei = bus.init; es = bus.stop;
`endif
      tg = ei && !m_prev;
      m_prev = ei;
      m_done = 0;
      if (es) begin
        m_active = 0;
      end else if (tg && bus.period != 0) begin
        m_active = 1;
        m_k = 0;
        m_per = int'(bus.period);
        m_wid = int'(bus.width);
        if (bus.mode == 2'd1)
          m_total = 0;
        else if (bus.mode == 2'd2)
          m_total = m_per * ((bus.burst_len == 0) ?
                    1 : int'(bus.burst_len));
        else
          m_total = m_per;
      end else if (m_active) begin
        m_k++;
        if (m_total > 0 && m_k == m_total) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end
  end

  // per-cycle compare against the model
  bit e_pulse;
  always @(negedge clk) begin
    if (rst_n) begin
      e_pulse = m_active && ((m_k % m_per) < m_wid);
      n_cmp += 3;
      if (bus.pulse !== e_pulse) begin
        n_fail++;
        $display("FAIL pulse t=%0t got %b exp %b",
                 $time, bus.pulse, e_pulse);
      end
      if (bus.busy !== m_active) begin
        n_fail++;
        $display("FAIL busy t=%0t got %b exp %b",
                 $time, bus.busy, m_active);
      end
      if (bus.done !== m_done) begin
        n_fail++;
        $display("FAIL done t=%0t got %b exp %b",
                 $time, bus.done, m_done);
      end
      cnt_pulse += int'(bus.pulse);
      cnt_busy  += int'(bus.busy);
      cnt_done  += int'(bus.done);
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr();
    cnt_pulse = 0; cnt_busy = 0; cnt_done = 0;
  endtask

  // counters start right after the trig edge
  task automatic fire(int md, int per, int wid, int bl);
    bus.mode = 2'(md);
    bus.period = CW'(per);
    bus.width = CW'(wid);
    bus.burst_len = BW'(bl);
    bus.init = 1'b1;
    cyc(LAT);
    clr();
    cyc(1);
    bus.init = 1'b0;
    bus.period = CW'(3);
    bus.width = CW'(2);
    bus.mode = 2'd1;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    cyc(LAT + 2);
  endtask

  initial begin
    bus.init = 0; bus.stop = 0; bus.mode = 0;
    bus.period = 0; bus.width = 0; bus.burst_len = 0;
    cyc(3);
    chk("rst_pulse", int'(bus.pulse), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    rst_n = 1'b1;
    cyc(2);

    // SINGLE p10 w3
    fire(0, 10, 3, 0);
    cyc(20);
    chk("single_pulse", cnt_pulse, 3);
    chk("single_busy", cnt_busy, 10);
    chk("single_done", cnt_done, 1);

    // PERIODIC p8 w2 then stop
    fire(1, 8, 2, 0);
    cyc(31);
    chk("per_pulse", cnt_pulse, 8);
    chk("per_busy", cnt_busy, 32);
    chk("per_done", cnt_done, 0);
    clr();
    do_stop();
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_done", cnt_done, 0);

    // BURST 3 x p5 w1, then burst_len 0
    fire(2, 5, 1, 3);
    cyc(24);
    chk("burst_pulse", cnt_pulse, 3);
    chk("burst_busy", cnt_busy, 15);
    chk("burst_done", cnt_done, 1);
    fire(2, 5, 1, 0);
    cyc(10);
    chk("burst0_pulse", cnt_pulse, 1);
    chk("burst0_busy", cnt_busy, 5);

    // retrigger PERIODIC with SINGLE p6
    fire(1, 8, 3, 0);
    cyc(3);
    fire(0, 6, 1, 0);
    cyc(15);
    chk("retrig_pulse", cnt_pulse, 1);
    chk("retrig_busy", cnt_busy, 6);
    chk("retrig_done", cnt_done, 1);

    // period 0 is ignored
    fire(0, 0, 3, 0);
    cyc(10);
    chk("p0_busy", cnt_busy, 0);

    // width 0 still completes
    fire(0, 5, 0, 0);
    cyc(10);
    chk("w0_pulse", cnt_pulse, 0);
    chk("w0_done", cnt_done, 1);

    // width > period: continuous high
    fire(1, 10, 12, 0);
    cyc(29);
    chk("wide_pulse", cnt_pulse, 30);
    do_stop();

    // init held high: one sequence only
    bus.mode = 0; bus.period = 4; bus.width = 2;
    bus.init = 1'b1;
    cyc(LAT);
    clr();
    cyc(50);
    bus.init = 1'b0;
    cyc(5);
    chk("held_done", cnt_done, 1);
    chk("held_busy", cnt_busy, 4);

    // reset mid-burst at cycle 7 (pulse high)
    fire(2, 5, 2, 3);
    cyc(6);
    chk("pre_rst_pulse", int'(bus.pulse), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pulse", int'(bus.pulse), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    fire(0, 7, 4, 0);
    cyc(12);
    chk("post_rst_pulse", cnt_pulse, 4);
    chk("post_rst_busy", cnt_busy, 7);
    chk("post_rst_done", cnt_done, 1);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        bus.mode = 2'($urandom_range(3));
        bus.period = CW'($urandom_range(12));
        bus.width = CW'($urandom_range(14));
        bus.burst_len = BW'($urandom_range(4));
      end
      bus.init = ($urandom_range(11) == 0);
      bus.stop = ($urandom_range(59) == 0);
      cyc(1);
    end
    bus.init = 0; bus.stop = 0;
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gen_ctrl.md
Name: pulse_gen_ctrl

Overview:
- Parametrised successor to the single/repeated pulse controller.
- Generates pulses with programmable width and period on a trigger edge, in one of three modes: SINGLE, PERIODIC, BURST of N pulses.
- Adds retrigger, synchronous stop, a busy flag and a done strobe.
- Sits between a control/register front-end and the pulse-driven datapath.

Parameters:
- CNT_W, 16, width of the period, width and phase counters.
- BURST_W, 8, width of the burst-count input and remaining-pulse counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init  in  1  trigger; its rising edge starts or restarts a sequence.
- stop  in  1  synchronous abort, level-sensitive.
- mode  in  2  00 SINGLE, 01 PERIODIC, 10 BURST, 11 reserved (treated as SINGLE).
- period  in  CNT_W  cycles per pulse period.
- width  in  CNT_W  high cycles per period.
- burst_len  in  BURST_W  pulses per burst.
- pulse  out  1  registered pulse output.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle strobe when a SINGLE or BURST sequence completes.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; pulse=0, busy=0, done=0.
  - ph=0, remaining=0, init_d=0.
- Trigger detection:
  - trig = init & ~init_d, with init_d registered every cycle.
  - init held high produces exactly one trig.
- Parameter latching: on trig, the block latches mode, period, width and burst_len; later changes to those inputs have no effect until the next trig.
- States: IDLE and RUN.
  - IDLE -> RUN on trig, when period != 0. A trig with period == 0 is ignored and the state does not change.
  - RUN -> RUN on end-of-period when mode is PERIODIC, or BURST with remaining > 1. Then ph=0, and remaining decrements in BURST.
  - RUN -> IDLE on end-of-period in SINGLE, or BURST with remaining == 1. done=1 for exactly that one cycle.
  - RUN -> IDLE on stop=1. No done strobe.
  - End-of-period means ph == period_l - 1.
- Latency:
  - trig is sampled at edge t.
  - pulse, busy and ph=0 are valid after edge t.
  - pulse stays high for width_l cycles out of every period_l cycles.
- Pulse equation: pulse is registered, = (state_next == RUN) && (ph_next < width_l).
  - width_l = 0: pulse stays low, but timing and done still run.
  - width_l >= period_l: pulse stays high for the whole sequence. PERIODIC mode therefore gives a continuous high.
- burst_len = 0 is treated as 1.
- Retrigger: trig while in RUN restarts immediately.
  - New parameters are latched, ph=0 and remaining reloads.
  - The old sequence produces no done.
- Simultaneous events:
  - stop has priority over trig.
  - stop and end-of-period in the same cycle produce IDLE with no done.
  - trig in IDLE while stop=1 is ignored.
- Counter width: ph never exceeds period_l - 1, so no wrap-around occurs.
- Reset mid-sequence: outputs drop to 0 asynchronously, and no done is issued.

Optional Feature:
- Macro: PULSE_GEN_CTRL_SYNC_EN.
- Defined: init and stop each pass through a 2-flop synchronizer before use, which adds 2 cycles of latency from an input edge to the pulse edge. Synchronizer flops reset to 0.
- Undefined: inputs are used directly as synchronous signals, with latency as stated above.

Decomposition:
- Shared package pulse_gen_pkg holds:
  - mode constants MODE_SINGLE, MODE_PERIODIC, MODE_BURST;
  - the state encoding ST_IDLE and ST_RUN;
  - default CNT_W and BURST_W.
- One natural sub-module: pulse_gen_edge, holding the optional synchronizer and the rising-edge detector. It is instantiated once for init; stop uses only its synchronizer path.

Test Plan:
1. SINGLE: period=10, width=3, pulse init at t0 -> pulse high for cycles 1-3 after the edge; busy for 10 cycles; done=1 on the 10th; then idle.
2. PERIODIC: period=8, width=2, 4 periods observed -> pulse pattern 11000000 repeating; busy stays high; done never asserts; then stop=1 -> pulse=0 and busy=0 on the next cycle, no done.
3. BURST: burst_len=3, period=5, width=1 -> exactly 3 one-cycle pulses, 5 cycles apart; done on cycle 15; burst_len=0 -> exactly 1 pulse.
4. Retrigger: PERIODIC running, init edge at phase 4 with mode=SINGLE, period=6 -> phase restarts at the new edge; one pulse; done after 6 cycles; no PERIODIC pulses afterwards.
5. Boundaries:
   - period=0 trig -> ignored, busy stays 0.
   - width=0 -> pulse stays 0, done still fires.
   - width=12, period=10 PERIODIC -> pulse held at 1.
   - init held high 50 cycles -> one sequence only.
6. Reset mid-burst: rst_n low at cycle 7 -> pulse, busy and done are 0 immediately. After release, init -> a fresh sequence with correct timing; with PULSE_GEN_CTRL_SYNC_EN, all latencies are +2 cycles.
